cache_ctrl_fsm: RTL and testbench

- Per-cache sequencing controller that drives the `func` and `snoop_out` controls of the cache datapath.
- Accepts one processor request at a time and resolves it using the datapath's `read_hit`/`stat` feedback.
- On a miss it snoops the peer cache, arbitrates for the shared bus, writes back a dirty victim, fills the line and completes the access.
- Sits between the processor interface, the bus arbiter/memory and one cache datapath instance.

---
 rtl/cache_ctrl_if.sv | 37 +++
 rtl/cache_ctrl_fsm.sv | 112 +++++++++++
 tb/tb_cache_ctrl_fsm.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// cache_ctrl_if: processor, bus and datapath signals of one cache controller.
// master is the controller side, slave is the surrounding environment.
interface cache_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             p_req;
  logic             p_rw;
  logic             read_hit;
  logic [1:0]       stat;
  logic             snoop_hit_in;
  logic             bus_gnt;
  logic             mem_ack;
  logic [1:0]       func;
  logic             snoop_out;
  logic             bus_req;
  logic             p_done;
  logic             p_err;
  logic             busy;
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;

  modport master (
    input  p_req, p_rw, read_hit, stat,
    input  snoop_hit_in, bus_gnt, mem_ack,
    output func, snoop_out, bus_req,
    output p_done, p_err, busy,
    output hit_cnt, miss_cnt
  );

  modport slave (
    output p_req, p_rw, read_hit, stat,
    output snoop_hit_in, bus_gnt, mem_ack,
    input  func, snoop_out, bus_req,
    input  p_done, p_err, busy,
    input  hit_cnt, miss_cnt
  );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// cache_ctrl_fsm: sequencing controller for one cache datapath.
// Resolves hits; on miss snoops, arbitrates, writes back and fills.
module cache_ctrl_fsm #(
  parameter int SNOOP_WAIT = 2,
  parameter int TIMEOUT    = 64,
  parameter int CNT_W      = 16
) (
  input  logic         clk,
  input  logic         reset,
  cache_ctrl_if.master bus
);
  typedef enum logic [3:0] {
    S_IDLE, S_LOOKUP, S_SNOOP, S_SWAIT,
    S_ARB, S_WB, S_FILL, S_RD,
    S_WRITE, S_RESP, S_ERR
  } state_t;

  localparam logic [7:0] SW_LAST = 8'(SNOOP_WAIT - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t           state, state_n;
  logic             rw_q, wb_q, snp_q;
  logic [7:0]       tmr;
  logic [CNT_W-1:0] hit_q, miss_q;
  logic             hit_inc, miss_inc;
  logic             timed;

  assign timed = (state == S_SNOOP) || (state == S_SWAIT)
              || (state == S_WB)    || (state == S_FILL);

  always_comb begin
    state_n  = state;
    hit_inc  = 1'b0;
    miss_inc = 1'b0;
    unique case (state)
      S_IDLE:
        if (bus.p_req) state_n = S_LOOKUP;
      S_LOOKUP:
        if (bus.read_hit) begin
          hit_inc = 1'b1;
          state_n = rw_q ? S_WRITE : S_RESP;
        end else begin
          miss_inc = 1'b1;
          state_n  = S_SNOOP;
        end
      S_SNOOP:
        if (tmr == SW_LAST)
          state_n = (snp_q || bus.snoop_hit_in) ? S_SWAIT : S_ARB;
      S_SWAIT:
        if (tmr == SW_LAST) state_n = S_ARB;
      S_ARB:
        if (bus.bus_gnt) state_n = wb_q ? S_WB : S_FILL;
      S_WB:
        if (bus.mem_ack)        state_n = S_FILL;
        else if (tmr == TO_LAST) state_n = S_ERR;
      S_FILL:
        if (bus.mem_ack)        state_n = rw_q ? S_WRITE : S_RD;
        else if (tmr == TO_LAST) state_n = S_ERR;
      S_RD, S_WRITE:
        state_n = S_RESP;
      S_RESP, S_ERR:
        state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // tmr restarts on every state change, so it times each phase alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      rw_q   <= 1'b0;
      wb_q   <= 1'b0;
      snp_q  <= 1'b0;
      tmr    <= '0;
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && bus.p_req)
        rw_q <= bus.p_rw;
      if (state == S_LOOKUP && !bus.read_hit)
        wb_q <= (bus.stat == 2'b11);
      else if (state == S_WB && bus.mem_ack)
        wb_q <= 1'b0;
      if (state != S_SNOOP)
        snp_q <= 1'b0;
      else if (bus.snoop_hit_in)
        snp_q <= 1'b1;
      if (state_n != state)
        tmr <= '0;
      else if (timed)
        tmr <= tmr + 8'd1;
      if (hit_inc && hit_q != '1)
        hit_q <= hit_q + 1'b1;
      if (miss_inc && miss_q != '1)
        miss_q <= miss_q + 1'b1;
    end
  end

  assign bus.func = (state == S_WB)    ? 2'b11 :
                    (state == S_FILL)  ? 2'b10 :
                    (state == S_WRITE) ? 2'b01 : 2'b00;
  assign bus.snoop_out = (state == S_SNOOP);
  assign bus.bus_req   = (state == S_ARB) || (state == S_WB)
                      || (state == S_FILL);
  assign bus.p_done    = (state == S_RESP) || (state == S_ERR);
  assign bus.p_err     = (state == S_ERR);
  assign bus.busy      = (state != S_IDLE);
  assign bus.hit_cnt   = hit_q;
  assign bus.miss_cnt  = miss_q;
endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// tb_cache_ctrl_fsm: directed and random transactions against a
// transaction-level latency/count model of the cache controller.
module tb_cache_ctrl_fsm;
  localparam int W    = 2;
  localparam int TO   = 64;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int checks   = 0;
  int failures = 0;
  int txn_id   = 0;
  int exp_hit  = 0;
  int exp_miss = 0;

  cache_ctrl_if #(.CNT_W(CW)) bif ();

  cache_ctrl_fsm #(
    .SNOOP_WAIT(W),
    .TIMEOUT(TO),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s txn=%0d obs=%0d exp=%0d",
             tag, txn_id, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bif.p_req        = 1'b0;
    bif.p_rw         = 1'b0;
    bif.read_hit     = 1'b0;
    bif.stat         = 2'b00;
    bif.snoop_hit_in = 1'b0;
    bif.bus_gnt      = 1'b0;
    bif.mem_ack      = 1'b0;
  endtask

  // snp_j: SNOOP cycle (1..W) on which the peer hits, 0 = never.
  // g: grant after g+1 ARB cycles. awb/afl: ack after a+1 cycles.
  // to_sel: 1 = memory never acks the fill, 2 = never acks the writeback.
  task automatic run_txn(input logic rw, input logic hit,
                         input logic [1:0] st, input int snp_j,
                         input int g, input int awb, input int afl,
                         input int to_sel);
    logic wb, eto, done, err;
    int e_lat, e_n01, e_n11, e_n10, e_req, e_sn;
    int lat, n01, n11, n10, nreq, nsn, reqc, run, sc;
    logic [1:0] lastf;
    txn_id++;
    wb  = !hit && (st == 2'b11);
    eto = !hit && ((to_sel == 1) || (to_sel == 2 && wb));
    if (hit) begin
      e_lat = rw ? 3 : 2;
      e_n01 = rw ? 1 : 0;
      e_n11 = 0; e_n10 = 0; e_req = 0; e_sn = 0;
      exp_hit = (exp_hit < CMAX) ? exp_hit + 1 : CMAX;
    end else begin
      e_n11 = wb ? ((to_sel == 2) ? TO : awb + 1) : 0;
      e_n10 = (to_sel == 2 && wb) ? 0 :
              (to_sel == 1) ? TO : afl + 1;
      e_sn  = W;
      e_req = g + 1 + e_n11 + e_n10;
      e_n01 = (!eto && rw) ? 1 : 0;
      e_lat = 1 + W + ((snp_j != 0) ? W : 0) + g + 1
            + e_n11 + e_n10 + (eto ? 1 : 2);
      exp_miss = (exp_miss < CMAX) ? exp_miss + 1 : CMAX;
    end
    lat = 0; n01 = 0; n11 = 0; n10 = 0; nreq = 0; nsn = 0;
    reqc = 0; run = 0; sc = 0; lastf = 2'b00;
    done = 1'b0; err = 1'b0;
    @(negedge clk);
    idle_inputs();
    bif.p_req    = 1'b1;
    bif.p_rw     = rw;
    bif.read_hit = hit;
    bif.stat     = st;
    for (int k = 1; k <= 800 && !done; k++) begin
      @(negedge clk);
      bif.p_req = 1'b0;
      bif.p_rw  = 1'($urandom);
      if (bif.func == 2'b01) n01++;
      if (bif.func == 2'b11) n11++;
      if (bif.func == 2'b10) n10++;
      if (bif.bus_req) nreq++;
      if (bif.snoop_out) nsn++;
      if (bif.p_done) begin
        done = 1'b1;
        lat  = k;
        err  = bif.p_err;
      end
      run   = (bif.func == lastf) ? run + 1 : 1;
      lastf = bif.func;
      if (bif.bus_req) reqc++;
      if (bif.snoop_out) sc++;
      bif.snoop_hit_in = bif.snoop_out && (sc == snp_j);
      bif.bus_gnt = bif.bus_req ? (reqc > g) : 1'($urandom);
      if (bif.func == 2'b11)
        bif.mem_ack = (to_sel != 2) && (run > awb);
      else if (bif.func == 2'b10)
        bif.mem_ack = (to_sel != 1) && (run > afl);
      else
        bif.mem_ack = 1'($urandom);
    end
    chk("done_seen", 32'(done), 1);
    chk("latency", lat, e_lat);
    chk("p_err", 32'(err), 32'(eto));
    chk("func01_cycles", n01, e_n01);
    chk("func11_cycles", n11, e_n11);
    chk("func10_cycles", n10, e_n10);
    chk("bus_req_cycles", nreq, e_req);
    chk("snoop_cycles", nsn, e_sn);
    chk("hit_cnt", 32'(bif.hit_cnt), exp_hit);
    chk("miss_cnt", 32'(bif.miss_cnt), exp_miss);
    @(negedge clk);
    idle_inputs();
    chk("done_pulse", 32'(bif.p_done), 0);
    chk("idle_after", 32'(bif.busy), 0);
  endtask

  initial begin
    logic reached;
    idle_inputs();
    #7;
    chk("rst_func", 32'(bif.func), 0);
    chk("rst_ctl", 32'({bif.snoop_out, bif.bus_req,
                        bif.p_done, bif.p_err, bif.busy}), 0);
    chk("rst_hit", 32'(bif.hit_cnt), 0);
    chk("rst_miss", 32'(bif.miss_cnt), 0);
    @(negedge clk);
    reset = 1'b1;

    run_txn(1'b0, 1'b1, 2'b10, 0, 0, 0, 0, 0);
    run_txn(1'b1, 1'b1, 2'b10, 0, 0, 0, 0, 0);
    run_txn(1'b0, 1'b0, 2'b11, 0, 2, 1, 1, 0);
    run_txn(1'b0, 1'b0, 2'b00, 1, 0, 0, 0, 0);
    run_txn(1'b0, 1'b0, 2'b10, 0, 0, 0, 0, 0);
    run_txn(1'b0, 1'b0, 2'b00, 0, 1, 0, 0, 1);
    run_txn(1'b1, 1'b0, 2'b11, W, 0, 0, 0, 2);

    for (int i = 0; i < 40; i++) begin
      run_txn(1'($urandom), ($urandom % 3) == 0,
              2'($urandom), $urandom_range(0, W),
              $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3),
              (($urandom % 8) == 0) ? $urandom_range(1, 2) : 0);
    end

    txn_id++;
    @(negedge clk);
    idle_inputs();
    bif.p_req   = 1'b1;
    bif.bus_gnt = 1'b1;
    reached = 1'b0;
    for (int k = 0; k < 50 && !reached; k++) begin
      @(negedge clk);
      bif.p_req = 1'b0;
      reached = (bif.func == 2'b10);
    end
    chk("fill_reached", 32'(reached), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_func", 32'(bif.func), 0);
    chk("arst_ctl", 32'({bif.snoop_out, bif.bus_req,
                         bif.p_done, bif.p_err, bif.busy}), 0);
    chk("arst_cnt", 32'({bif.hit_cnt, bif.miss_cnt}), 0);
    exp_hit  = 0;
    exp_miss = 0;
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    run_txn(1'b0, 1'b1, 2'b10, 0, 0, 0, 0, 0);

    for (int i = 0; i < (1 << CW) + 3; i++)
      run_txn(1'($urandom), 1'b1, 2'($urandom), 0, 0, 0, 0, 0);
    chk("hit_saturated", 32'(bif.hit_cnt), CMAX);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
